// File: rtl/cnn_layer_accel_result_packer.sv
// Result packer: gathers eight 16-bit quad results into one 128-bit word,
// buffers packed words in a small FIFO and reports job completion.
module cnn_layer_accel_result_packer #(
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_CNT_WIDTH  = 20
) (
    input  logic                   clk_core,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [C_CNT_WIDTH-1:0] cfg_num_results,
    input  logic                   result_valid,
    output logic                   result_accept,
    input  logic [15:0]            result_data,
    output logic                   pack_valid,
    input  logic                   pack_ready,
    output logic [127:0]           pack_data,
    output logic [7:0]             pack_keep,
    output logic                   pack_last,
    output logic                   busy,
    output logic                   job_done
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int EW = 137;
    localparam logic [AW:0] FULL_V = (AW+1)'(C_FIFO_DEPTH);
    localparam logic [C_CNT_WIDTH-1:0] ONE_V = C_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [C_CNT_WIDTH-1:0] cnt_q;
    logic [C_CNT_WIDTH-1:0] cnt_d;
    logic [2:0]             idx_q;
    logic [2:0]             idx_d;
    logic [111:0]           part_q;
    logic [111:0]           part_d;
    logic [EW-1:0]          mem_q [C_FIFO_DEPTH];
    logic [EW-1:0]          mem_d [C_FIFO_DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          wr_d;
    logic [AW-1:0]          rd_q;
    logic [AW-1:0]          rd_d;
    logic [AW:0]            occ_q;
    logic [AW:0]            occ_d;
    logic                   done_q;
    logic                   done_d;

    logic                   acc;
    logic                   fin;
    logic                   push;
    logic                   pop;
    logic [127:0]           word;
    logic [7:0]             keep;
    logic [EW-1:0]          head;

    // Handshakes, word assembly and the FIFO head view.
    always_comb begin
        result_accept = (state_q == S_RUN) && (occ_q < FULL_V);
        acc           = result_valid && result_accept;
        fin           = acc && (cnt_q == ONE_V);
        push          = acc && ((idx_q == 3'd7) || fin);
        head          = mem_q[rd_q];
        pack_valid    = (occ_q != '0);
        pop           = pack_valid && pack_ready;
        word          = {16'h0000, part_q};
        word[{idx_q, 4'b0000} +: 16] = result_data;
        // Lanes 0..idx are populated; the rest stay zero.
        keep          = 8'hFF >> (3'd7 - idx_q);
    end

    // Outputs are forced to zero while the FIFO is empty.
    always_comb begin
        pack_data = '0;
        pack_keep = '0;
        pack_last = 1'b0;
        if (pack_valid) begin
            pack_data = head[127:0];
            pack_keep = head[135:128];
            pack_last = head[136];
        end
        busy     = (state_q != S_IDLE);
        job_done = done_q;
    end

    // Lane index, partial word and results-remaining counter.
    always_comb begin
        idx_d  = idx_q;
        part_d = part_q;
        cnt_d  = cnt_q;
        if ((state_q == S_IDLE) && cfg_load) begin
            cnt_d = cfg_num_results;
        end
        if (acc) begin
            cnt_d = cnt_q - ONE_V;
            if (push) begin
                idx_d  = '0;
                part_d = '0;
            end else begin
                idx_d  = idx_q + 3'd1;
                part_d = word[111:0];
            end
        end
    end

    // Packed-word FIFO: push completed words, pop on the output handshake.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push) begin
            mem_d[wr_q] = {fin, keep, word};
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Job sequencing: run until the last result, drain until it leaves.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    if (cfg_num_results == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (fin) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head[136]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset discards any job in flight.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            part_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Directed bench for the result packer: packing, keep/last, backpressure,
// zero-count jobs, reset mid-job and ignored reconfiguration.
module tb_cnn_layer_accel_result_packer;

    logic         clk_core;
    logic         rst;
    logic         cfg_load;
    logic [19:0]  cfg_num_results;
    logic         result_valid;
    logic         result_accept;
    logic [15:0]  result_data;
    logic         pack_valid;
    logic         pack_ready;
    logic [127:0] pack_data;
    logic [7:0]   pack_keep;
    logic         pack_last;
    logic         busy;
    logic         job_done;

    int n_chk = 0;
    int n_pass = 0;

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    cnn_layer_accel_result_packer #(
        .C_FIFO_DEPTH(4),
        .C_CNT_WIDTH (20)
    ) dut (
        .clk_core       (clk_core),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .cfg_num_results(cfg_num_results),
        .result_valid   (result_valid),
        .result_accept  (result_accept),
        .result_data    (result_data),
        .pack_valid     (pack_valid),
        .pack_ready     (pack_ready),
        .pack_data      (pack_data),
        .pack_keep      (pack_keep),
        .pack_last      (pack_last),
        .busy           (busy),
        .job_done       (job_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected word j of an n-result job whose results are base, base+1, ...
    function automatic logic [136:0] exp_word(input int base, input int j,
                                              input int n);
        logic [127:0] d;
        logic [7:0]   k;
        int           r;
        d = '0;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            r = 8 * j + i;
            if (r < n) begin
                d[i*16 +: 16] = 16'(base + r);
                k[i] = 1'b1;
            end
        end
        return {(j == ((n + 7) / 8) - 1), k, d};
    endfunction

    // mode 0: ready always high, 1: random ready, 2: ready low until full
    task automatic job(input int n, input int base, input int mode,
                       input bit inj);
        int sent = 0;
        int words = 0;
        int cyc = 0;
        bit prev_stall = 0;
        bit exp_done = 0;
        bit nxt_done;
        bit exp_pv = 0;
        bit done_seen = 0;
        bit injected = 0;
        bit hold;
        logic [127:0] prev_d = '0;
        logic [136:0] ew;
        hold = (mode == 2);
        @(negedge clk_core);
        cfg_load = 1'b1;
        cfg_num_results = 20'(n);
        @(negedge clk_core);
        cfg_load = 1'b0;
        chk("busy_rise", busy, 1);
        while (!done_seen && cyc < 3000) begin
            nxt_done = 0;
            if (job_done) done_seen = 1;
            if (job_done || exp_done) chk("job_done", job_done, exp_done);
            if (prev_stall) begin
                chk("stall_valid", pack_valid, 1);
                chk("stall_data", pack_data, prev_d);
            end
            if (exp_pv) chk("latency", pack_valid, 1);
            exp_pv = 0;
            cfg_load = 1'b0;
            if (inj && !injected && sent == 5) begin
                cfg_load = 1'b1;
                cfg_num_results = 20'd100;
                injected = 1;
            end
            if (hold && !result_accept && sent < n) begin
                chk("full_accepts", sent, 32);
                hold = 0;
            end
            case (mode)
                1:       pack_ready = 1'($urandom_range(0, 1));
                2:       pack_ready = !hold;
                default: pack_ready = 1'b1;
            endcase
            result_valid = (sent < n);
            result_data = 16'(base + sent);
            if (pack_valid && pack_ready) begin
                ew = exp_word(base, words, n);
                chk("word_data", pack_data, ew[127:0]);
                chk("word_keep", pack_keep, ew[135:128]);
                chk("word_last", pack_last, ew[136]);
                if (ew[136]) nxt_done = 1;
                words++;
            end
            if (result_valid && result_accept) begin
                sent++;
                if (mode == 0 && (sent % 8 == 0 || sent == n)) exp_pv = 1;
            end
            prev_stall = pack_valid && !pack_ready;
            prev_d = pack_data;
            exp_done = nxt_done;
            cyc++;
            @(negedge clk_core);
        end
        cfg_load = 1'b0;
        result_valid = 1'b0;
        chk("no_timeout", done_seen, 1);
        chk("word_count", words, (n + 7) / 8);
        chk("sent_count", sent, n);
        chk("done_one_cycle", job_done, 0);
        chk("idle_after", busy, 0);
        chk("no_extra_word", pack_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_load = 1'b0;
        cfg_num_results = '0;
        result_valid = 1'b0;
        result_data = '0;
        pack_ready = 1'b0;
        repeat (2) @(negedge clk_core);
        rst = 1'b0;
        result_valid = 1'b1;
        pack_ready = 1'b1;
        @(negedge clk_core);
        chk("rst_accept_idle", result_accept, 0);
        chk("rst_pack_valid", pack_valid, 0);
        chk("rst_pack_data", pack_data, 0);
        chk("rst_pack_keep", pack_keep, 0);
        chk("rst_pack_last", pack_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_job_done", job_done, 0);
        result_valid = 1'b0;

        job(16, 1, 0, 0);
        job(11, 16'h0201, 0, 0);
        job(40, 16'h1000, 2, 0);

        @(negedge clk_core);
        cfg_load = 1'b1;
        cfg_num_results = '0;
        @(negedge clk_core);
        cfg_load = 1'b0;
        chk("zero_done", job_done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_valid", pack_valid, 0);
        @(negedge clk_core);
        chk("zero_done_end", job_done, 0);
        chk("zero_valid_end", pack_valid, 0);

        job(24, 16'h2000, 1, 0);

        @(negedge clk_core);
        cfg_load = 1'b1;
        cfg_num_results = 20'd16;
        @(negedge clk_core);
        cfg_load = 1'b0;
        pack_ready = 1'b1;
        result_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            result_data = 16'(16'h0F00 + i);
            @(negedge clk_core);
        end
        result_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk_core);
        rst = 1'b0;
        chk("mid_rst_accept", result_accept, 0);
        chk("mid_rst_valid", pack_valid, 0);
        chk("mid_rst_data", pack_data, 0);
        chk("mid_rst_keep", pack_keep, 0);
        chk("mid_rst_last", pack_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", job_done, 0);
        repeat (3) @(negedge clk_core);
        chk("mid_rst_no_done", job_done, 0);
        chk("mid_rst_no_word", pack_valid, 0);

        job(8, 16'h0A00, 0, 0);
        job(16, 16'h3000, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
